// File: rtl/axil_bram_mc_pkg.sv
// Shared types for the multichannel AXI-Lite BRAM: FSM encoding and AXI response codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axil_bram_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RRESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_mc_lane_ram.sv
// One AXI-width lane of a channel: true dual-port RAM, byte-enable AXI port, full-word FPGA port.
// Latency: 1 cycle read on both ports (2 with AXIL_BRAM_MC_OUTREG_EN), read-first on both ports.
// Backpressure: none; both ports are always enabled. An FPGA write to the same word overrides the AXI bytes.
module axil_bram_mc_lane_ram #(
    parameter int    DATA_W   = 32,
    parameter int    ADDR_W   = 10,
    parameter string RAM_TYPE = "block"
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic [DATA_W-1:0]   a_rdata_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic                b_we_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    output logic [DATA_W-1:0]   b_rdata_o
);

    (* ram_style = RAM_TYPE *) logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              a_blocked;

    // The FPGA port owns the whole word when both ports write the same address
    assign a_blocked = b_we_i && (a_addr_i == b_addr_i);

    // Memory array writes: AXI byte lanes first, then the FPGA full word
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (a_be_i[i] && !a_blocked) begin
                mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            end
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // Registered read-first outputs, cleared by reset (array contents are not)
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= mem_q[a_addr_i];
            b_q <= mem_q[b_addr_i];
        end
    end

`ifdef AXIL_BRAM_MC_OUTREG_EN
    logic [DATA_W-1:0] a_out_q;
    logic [DATA_W-1:0] b_out_q;

    // Extra output pipeline stage for timing closure on wide fan-out
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            a_out_q <= a_q;
            b_out_q <= b_q;
        end
    end

    assign a_rdata_o = a_out_q;
    assign b_rdata_o = b_out_q;
`else
    assign a_rdata_o = a_q;
    assign b_rdata_o = b_q;
`endif

endmodule

// File: rtl/axil_bram_multichannel.sv
// N independent wide BRAMs, each with an FPGA port, sharing one AXI4-Lite slave (optional macro AXIL_BRAM_MC_OUTREG_EN).
// Latency: AXI write 2 cycles/txn; arready->rvalid 2 cycles (3 with macro); fpga_dout 1 cycle (2 with macro).
// Backpressure: one transaction in flight; bvalid/rvalid and their data hold until bready/rready.
module axil_bram_multichannel
    import axil_bram_mc_pkg::*;
#(
    parameter int    N_CHANNELS      = 4,
    parameter int    FPGA_DATA_WIDTH = 64,
    parameter int    FPGA_ADDR_WIDTH = 10,
    parameter int    AXI_DATA_WIDTH  = 32,
    parameter int    DEINTERLEAVE    = FPGA_DATA_WIDTH / AXI_DATA_WIDTH,
    parameter int    CH_BITS         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    parameter int    AXI_ADDR_WIDTH  = CH_BITS + FPGA_ADDR_WIDTH + $clog2(DEINTERLEAVE),
    parameter string RAM_TYPE        = "block"
) (
    input  logic                                  axi_clock,
    input  logic                                  rst_n,
    input  logic [AXI_ADDR_WIDTH+1:0]             s_axil_awaddr,
    input  logic [2:0]                            s_axil_awprot,
    input  logic                                  s_axil_awvalid,
    output logic                                  s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]             s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]           s_axil_wstrb,
    input  logic                                  s_axil_wvalid,
    output logic                                  s_axil_wready,
    output logic [1:0]                            s_axil_bresp,
    output logic                                  s_axil_bvalid,
    input  logic                                  s_axil_bready,
    input  logic [AXI_ADDR_WIDTH+1:0]             s_axil_araddr,
    input  logic [2:0]                            s_axil_arprot,
    input  logic                                  s_axil_arvalid,
    output logic                                  s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]             s_axil_rdata,
    output logic [1:0]                            s_axil_rresp,
    output logic                                  s_axil_rvalid,
    input  logic                                  s_axil_rready,
    input  logic [N_CHANNELS*FPGA_ADDR_WIDTH-1:0] fpga_addr,
    input  logic [N_CHANNELS*FPGA_DATA_WIDTH-1:0] fpga_din,
    input  logic [N_CHANNELS-1:0]                 fpga_we,
    output logic [N_CHANNELS*FPGA_DATA_WIDTH-1:0] fpga_dout
);

    localparam int LANE_BITS = $clog2(DEINTERLEAVE);
    localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int STRB_W    = AXI_DATA_WIDTH / 8;
`ifdef AXIL_BRAM_MC_OUTREG_EN
    localparam int RD_CYCLES = 2;
`else
    localparam int RD_CYCLES = 1;
`endif

    // Byte address split: [1:0] dropped | lane | word | channel
    function automatic logic [CH_BITS-1:0] ch_of(input logic [AXI_ADDR_WIDTH+1:0] a);
        return CH_BITS'(a >> (2 + LANE_BITS + FPGA_ADDR_WIDTH));
    endfunction
    function automatic logic [FPGA_ADDR_WIDTH-1:0] word_of(input logic [AXI_ADDR_WIDTH+1:0] a);
        return FPGA_ADDR_WIDTH'(a >> (2 + LANE_BITS));
    endfunction
    function automatic logic [LANE_W-1:0] lane_of(input logic [AXI_ADDR_WIDTH+1:0] a);
        return (LANE_BITS == 0) ? '0 : LANE_W'(a >> 2);
    endfunction

    state_e                     state_q, state_d;
    logic                       rr_q;           // 0: write wins next contention, 1: read wins
    logic [1:0]                 bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q, rd_mux;
    logic [CH_BITS-1:0]         rsel_ch_q;
    logic [LANE_W-1:0]          rsel_lane_q;
    logic                       rbad_q;
    logic                       rd_cnt_q;
    logic                       rd_last;
    logic                       wr_pend, rd_pend, grant_wr, grant_rd;
    logic [FPGA_ADDR_WIDTH-1:0] ram_axi_addr;
    logic [CH_BITS-1:0]         aw_ch;
    logic [LANE_W-1:0]          aw_lane;
    logic                       aw_bad, ar_bad;
    logic [AXI_DATA_WIDTH-1:0]  lane_rdata [N_CHANNELS][DEINTERLEAVE];
    logic                       unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};
    assign aw_ch       = ch_of(s_axil_awaddr);
    assign aw_lane     = lane_of(s_axil_awaddr);
    assign aw_bad      = int'(aw_ch) >= N_CHANNELS;
    assign ar_bad      = int'(ch_of(s_axil_araddr)) >= N_CHANNELS;
    assign rd_last     = (rd_cnt_q == 1'(RD_CYCLES - 1));

    // State register
    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; the write handshake completes inside IDLE, so WR only recovers to WRESP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_wr) state_d = WRESP;
                     else if (grant_rd) state_d = RD;
            WR:      state_d = WRESP;
            WRESP:   if (s_axil_bready) state_d = IDLE;
            RD:      if (rd_last) state_d = RRESP;
            RRESP:   if (s_axil_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: arbitration grants (Mealy in IDLE, masked while in reset) and response valids
    always_comb begin
        wr_pend        = s_axil_awvalid && s_axil_wvalid;
        rd_pend        = s_axil_arvalid;
        grant_wr       = rst_n && (state_q == IDLE) && wr_pend && (!rd_pend || !rr_q);
        grant_rd       = rst_n && (state_q == IDLE) && rd_pend && (!wr_pend || rr_q);
        s_axil_awready = grant_wr;
        s_axil_wready  = grant_wr;
        s_axil_arready = grant_rd;
        s_axil_bvalid  = (state_q == WRESP);
        s_axil_rvalid  = (state_q == RRESP);
        ram_axi_addr   = grant_wr ? word_of(s_axil_awaddr) : word_of(s_axil_araddr);
    end

    // Response, read-select and round-robin bookkeeping
    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            rsel_ch_q   <= '0;
            rsel_lane_q <= '0;
            rbad_q      <= 1'b0;
            rd_cnt_q    <= 1'b0;
        end else begin
            if (grant_wr && rd_pend)      rr_q <= 1'b1;
            else if (grant_rd && wr_pend) rr_q <= 1'b0;
            if (grant_wr) bresp_q <= aw_bad ? RESP_SLVERR : RESP_OKAY;
            if (grant_rd) begin
                rresp_q     <= ar_bad ? RESP_SLVERR : RESP_OKAY;
                rsel_ch_q   <= ch_of(s_axil_araddr);
                rsel_lane_q <= lane_of(s_axil_araddr);
                rbad_q      <= ar_bad;
            end
            if (state_q == RD && !rd_last) rd_cnt_q <= rd_cnt_q + 1'b1;
            else                           rd_cnt_q <= 1'b0;
            if (state_q == RD && rd_last) rdata_q <= rbad_q ? '0 : rd_mux;
        end
    end

    // Select the addressed lane using the channel/lane captured at arready
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            for (int l = 0; l < DEINTERLEAVE; l++) begin
                if (rsel_ch_q == CH_BITS'(c) && rsel_lane_q == LANE_W'(l)) rd_mux = lane_rdata[c][l];
            end
        end
    end

    assign s_axil_bresp = bresp_q;
    assign s_axil_rresp = rresp_q;
    assign s_axil_rdata = rdata_q;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        for (genvar l = 0; l < DEINTERLEAVE; l++) begin : g_lane
            logic [STRB_W-1:0] be;
            assign be = (grant_wr && aw_ch == CH_BITS'(c) && aw_lane == LANE_W'(l)) ? s_axil_wstrb : '0;

            axil_bram_mc_lane_ram #(
                .DATA_W   (AXI_DATA_WIDTH),
                .ADDR_W   (FPGA_ADDR_WIDTH),
                .RAM_TYPE (RAM_TYPE)
            ) u_ram (
                .clk_i     (axi_clock),
                .rst_n_i   (rst_n),
                .a_addr_i  (ram_axi_addr),
                .a_be_i    (be),
                .a_wdata_i (s_axil_wdata),
                .a_rdata_o (lane_rdata[c][l]),
                .b_addr_i  (fpga_addr[c*FPGA_ADDR_WIDTH +: FPGA_ADDR_WIDTH]),
                .b_we_i    (fpga_we[c]),
                .b_wdata_i (fpga_din[c*FPGA_DATA_WIDTH + l*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]),
                .b_rdata_o (fpga_dout[c*FPGA_DATA_WIDTH + l*AXI_DATA_WIDTH +: AXI_DATA_WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_axil_bram_multichannel.sv
// Directed bench for axil_bram_multichannel with 3 channels of 64-bit words over a 32-bit AXI-Lite port.
// Latency: expectations switch with AXIL_BRAM_MC_OUTREG_EN.
// Backpressure: exercises contention, stalled responses and reset during a response.
module tb_axil_bram_multichannel;

    localparam int NCH = 3;
    localparam int FA  = 10;
    localparam int FW  = 64;
`ifdef AXIL_BRAM_MC_OUTREG_EN
    localparam int RD_LAT   = 3;
    localparam int FPGA_LAT = 2;
`else
    localparam int RD_LAT   = 2;
    localparam int FPGA_LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [14:0]     awaddr, araddr;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [31:0]     wdata, rdata;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;
    logic [NCH*FA-1:0] fpga_addr;
    logic [NCH*FW-1:0] fpga_din, fpga_dout;
    logic [NCH-1:0]    fpga_we;

    int errors = 0;
    int checks = 0;
    int both_ready_cnt = 0;

    always #5 clk = ~clk;

    axil_bram_multichannel #(
        .N_CHANNELS(NCH), .FPGA_DATA_WIDTH(FW), .FPGA_ADDR_WIDTH(FA), .AXI_DATA_WIDTH(32)
    ) dut (
        .axi_clock(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .fpga_addr(fpga_addr), .fpga_din(fpga_din), .fpga_we(fpga_we), .fpga_dout(fpga_dout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
        chk("wr_handshake", {63'd0, awready && wready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 20);
        chk("wr_bvalid", {63'd0, bvalid}, 64'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [14:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        int lat;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        chk("rd_arready", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < 20);
        chk("rd_latency", 64'(lat), 64'(RD_LAT));
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic fpga_write(input int c, input logic [FA-1:0] a, input logic [FW-1:0] d);
        @(posedge clk); #1;
        fpga_addr[c*FA +: FA] = a; fpga_din[c*FW +: FW] = d; fpga_we[c] = 1'b1;
        @(posedge clk); #1;
        fpga_we[c] = 1'b0;
    endtask

    // Present write and read together; report which side got its ready first
    task automatic contend(input logic [14:0] a, input logic [31:0] d, output int first,
                           output logic [31:0] rd);
        bit wdone, rdone, bdone, rvdone;
        wdone = 0; rdone = 0; bdone = 0; rvdone = 0; first = 0; rd = '0;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = 4'hF; araddr = a;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 40 && !(bdone && rvdone); i++) begin
            @(negedge clk);
            if (awready && arready) both_ready_cnt++;
            if (awready && wready && awvalid) begin if (first == 0) first = 1; wdone = 1; end
            if (arready && arvalid) begin if (first == 0) first = 2; rdone = 1; end
            if (bvalid) bdone = 1;
            if (rvalid) begin rvdone = 1; rd = rdata; end
            @(posedge clk); #1;
            if (wdone) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (rdone) arvalid = 1'b0;
        end
        bready = 1'b0; rready = 1'b0;
        chk("contend_done", {63'd0, bdone && rvdone}, 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          first;
        int          n;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        fpga_addr = '0; fpga_din = '0; fpga_we = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", {61'd0, awready, wready, arready}, 64'd0);
        chk("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
        chk("rst_resp", {60'd0, bresp, rresp}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_fpga_dout", {63'd0, |fpga_dout}, 64'd0);
        rst_n = 1'b1;

        // Contention from reset: write first, then read first on the repeat
        contend(15'h2018, 32'h55, first, d);
        chk("rr_round1_first", 64'(first), 64'd1);
        chk("rr_round1_rdata", {32'd0, d}, 64'h55);
        contend(15'h2018, 32'h66, first, d);
        chk("rr_round2_first", 64'(first), 64'd2);
        chk("rr_round2_rdata", {32'd0, d}, 64'h55);
        chk("rr_no_dual_ready", 64'(both_ready_cnt), 64'd0);
        axi_read(15'h2018, d, r);
        chk("rr_round2_wrote", {32'd0, d}, 64'h66);

        // AXI lanes assemble into one FPGA word, FPGA read latency
        fpga_write(0, 10'd1, 64'h1111_2222_3333_4444);
        axi_write(15'h0000, 32'hDEADBEEF, 4'hF, r);
        chk("t1_bresp0", {62'd0, r}, 64'd0);
        axi_write(15'h0004, 32'h01234567, 4'hF, r);
        @(posedge clk); #1;
        fpga_addr[0 +: FA] = 10'd1;
        repeat (3) @(posedge clk);
        #1 fpga_addr[0 +: FA] = 10'd0;
        repeat (FPGA_LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("fpga_lat_old", fpga_dout[0 +: FW], 64'h1111_2222_3333_4444);
        @(posedge clk); @(negedge clk);
        chk("t1_fpga_dout", fpga_dout[0 +: FW], 64'h01234567_DEADBEEF);

        // FPGA port is read-first
        @(posedge clk); #1;
        fpga_din[0 +: FW] = 64'hCAFE0000_BEEF0001; fpga_we[0] = 1'b1;
        @(posedge clk); #1;
        fpga_we[0] = 1'b0;
        repeat (FPGA_LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("rdfirst_old", fpga_dout[0 +: FW], 64'h01234567_DEADBEEF);
        @(posedge clk); @(negedge clk);
        chk("rdfirst_new", fpga_dout[0 +: FW], 64'hCAFE0000_BEEF0001);

        // FPGA write, AXI reads each lane
        fpga_write(2, 10'd5, 64'hAAAA5555_12345678);
        axi_read(15'h402C, d, r);
        chk("t2_lane1", {32'd0, d}, 64'hAAAA5555);
        chk("t2_rresp", {62'd0, r}, 64'd0);
        axi_read(15'h4028, d, r);
        chk("t2_lane0", {32'd0, d}, 64'h12345678);

        // Byte strobes
        axi_write(15'h0010, 32'h0, 4'hF, r);
        axi_write(15'h0010, 32'hFFFFFFFF, 4'b0101, r);
        axi_read(15'h0010, d, r);
        chk("t3_strobe", {32'd0, d}, 64'h00FF00FF);

        // Invalid channel 3
        axi_write(15'h6000, 32'hCAFEF00D, 4'hF, r);
        chk("t4_bresp", {62'd0, r}, 64'd2);
        axi_read(15'h6000, d, r);
        chk("t4_rresp", {62'd0, r}, 64'd2);
        chk("t4_rdata", {32'd0, d}, 64'd0);
        axi_read(15'h0000, d, r);
        chk("t4_ch0_kept", {32'd0, d}, 64'hBEEF0001);
        axi_read(15'h2018, d, r);
        chk("t4_ch1_kept", {32'd0, d}, 64'h66);
        axi_read(15'h402C, d, r);
        chk("t4_ch2_kept", {32'd0, d}, 64'hAAAA5555);

        // Same-cycle FPGA and AXI write to ch1 word0: FPGA wins
        @(posedge clk); #1;
        awaddr = 15'h2000; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        fpga_addr[FA +: FA] = 10'd0; fpga_din[FW +: FW] = 64'h1; fpga_we[1] = 1'b1;
        @(negedge clk);
        chk("coll_same_cycle", {63'd0, awready && wready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; fpga_we[1] = 1'b0; bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 20);
        chk("coll_bresp", {61'd0, bvalid, bresp}, 64'h4);
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(15'h2000, d, r);
        chk("coll_fpga_wins", {32'd0, d}, 64'h1);

        // AXI read in the same cycle as an FPGA write returns old data
        @(posedge clk); #1;
        araddr = 15'h2000; arvalid = 1'b1; fpga_din[FW +: FW] = 64'h9; fpga_we[1] = 1'b1;
        @(negedge clk);
        chk("rw_same_arready", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; fpga_we[1] = 1'b0; rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 20);
        chk("rw_same_old", {32'd0, rdata}, 64'h1);
        @(posedge clk); #1;
        rready = 1'b0;
        axi_read(15'h2000, d, r);
        chk("rw_same_new", {32'd0, d}, 64'h9);

        // Stalled read response holds, then reset during RRESP
        @(posedge clk); #1;
        araddr = 15'h402C; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rvalid", {63'd0, rvalid}, 64'd1);
            chk("stall_rdata", {32'd0, rdata}, 64'hAAAA5555);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_mid_rdata", {32'd0, rdata}, 64'd0);
        #5 rst_n = 1'b1;
        axi_read(15'h402C, d, r);
        chk("rst_mem_kept", {32'd0, d}, 64'hAAAA5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
